// File: rtl/vdff_share_arbiter.sv
// Two-requester shared delayed register.
// A grant captures the winner's data into a shadow register. DELAY edges later,
// the shadow value is published on out with a one-cycle out_valid pulse.
// When both requesters ask together, the one not granted last time wins.
module vdff_share_arbiter #(
   parameter int SIZE  = 5,
   parameter int DELAY = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic            req1,
   input  logic [SIZE-1:0] in0,
   input  logic [SIZE-1:0] in1,
   output logic            gnt0,
   output logic            gnt1,
   output logic [SIZE-1:0] out,
   output logic            out_valid,
   output logic            out_src,
   output logic            busy
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(DELAY - 1);

   state_t          r_state,  w_state_n;
   logic [7:0]      r_cnt,    w_cnt_n;
   logic [SIZE-1:0] r_shadow, w_shadow_n;
   logic            r_win,    w_win_n;
   logic            r_last,   w_last_n;
   logic            r_gnt0,   w_gnt0_n;
   logic            r_gnt1,   w_gnt1_n;
   logic [SIZE-1:0] r_out,    w_out_n;
   logic            r_valid,  w_valid_n;
   logic            r_src,    w_src_n;
   logic            r_busy,   w_busy_n;
   logic            w_pick1;

   // Register all state and outputs; reset drops any in-flight transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_win    <= 1'b0;
         r_last   <= 1'b1;
         r_gnt0   <= 1'b0;
         r_gnt1   <= 1'b0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         r_src    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_shadow <= w_shadow_n;
         r_win    <= w_win_n;
         r_last   <= w_last_n;
         r_gnt0   <= w_gnt0_n;
         r_gnt1   <= w_gnt1_n;
         r_out    <= w_out_n;
         r_valid  <= w_valid_n;
         r_src    <= w_src_n;
         r_busy   <= w_busy_n;
      end
   end

   // Compute the next state and the next values of the registered outputs
   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_shadow_n = r_shadow;
      w_win_n    = r_win;
      w_last_n   = r_last;
      w_gnt0_n   = 1'b0;
      w_gnt1_n   = 1'b0;
      w_out_n    = r_out;
      w_valid_n  = 1'b0;
      w_src_n    = r_src;
      w_busy_n   = 1'b0;
      // Requester 1 wins if it is the only one asking, or if both ask and 0 won last time
      w_pick1    = req1 && (!req0 || !r_last);
      unique case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_gnt0_n   = !w_pick1;
               w_gnt1_n   = w_pick1;
               w_shadow_n = w_pick1 ? in1 : in0;
               w_win_n    = w_pick1;
               w_cnt_n    = CNT_LOAD;
               w_busy_n   = 1'b1;
               w_state_n  = HOLD;
            end
         end
         HOLD: begin
            w_busy_n = 1'b1;
            if (r_cnt != 8'd0) begin
               w_cnt_n = r_cnt - 8'd1;
            end else begin
               w_out_n   = r_shadow;
               w_src_n   = r_win;
               w_valid_n = 1'b1;
               w_last_n  = r_win;
               w_state_n = IDLE;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign out       = r_out;
   assign out_valid = r_valid;
   assign out_src   = r_src;
   assign busy      = r_busy;

endmodule

// File: tb/tb_vdff_share_arbiter.sv
// Directed bench for vdff_share_arbiter: three instances
// (5/10, 10/20 and 5/1 for SIZE/DELAY) share the clock and reset.
module tb_vdff_share_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // instance A: SIZE=5, DELAY=10
   logic       a_r0 = 0, a_r1 = 0;
   logic [4:0] a_i0 = '0, a_i1 = '0;
   logic       a_g0, a_g1, a_v, a_s, a_b;
   logic [4:0] a_o;
   // instance B: SIZE=10, DELAY=20
   logic       b_r0 = 0, b_r1 = 0;
   logic [9:0] b_i0 = '0, b_i1 = '0;
   logic       b_g0, b_g1, b_v, b_s, b_b;
   logic [9:0] b_o;
   // instance C: SIZE=5, DELAY=1
   logic       c_r0 = 0, c_r1 = 0;
   logic [4:0] c_i0 = '0, c_i1 = '0;
   logic       c_g0, c_g1, c_v, c_s, c_b;
   logic [4:0] c_o;

   int checks   = 0;
   int failures = 0;

   vdff_share_arbiter #(.SIZE(5), .DELAY(10)) u_a (
      .clk(clk), .rst(rst), .req0(a_r0), .req1(a_r1), .in0(a_i0), .in1(a_i1),
      .gnt0(a_g0), .gnt1(a_g1), .out(a_o), .out_valid(a_v), .out_src(a_s), .busy(a_b));

   vdff_share_arbiter #(.SIZE(10), .DELAY(20)) u_b (
      .clk(clk), .rst(rst), .req0(b_r0), .req1(b_r1), .in0(b_i0), .in1(b_i1),
      .gnt0(b_g0), .gnt1(b_g1), .out(b_o), .out_valid(b_v), .out_src(b_s), .busy(b_b));

   vdff_share_arbiter #(.SIZE(5), .DELAY(1)) u_c (
      .clk(clk), .rst(rst), .req0(c_r0), .req1(c_r1), .in0(c_i0), .in1(c_i1),
      .gnt0(c_g0), .gnt1(c_g1), .out(c_o), .out_valid(c_v), .out_src(c_s), .busy(c_b));

   always #5 clk = ~clk;

   typedef struct {
      logic       r0, r1;
      logic [4:0] i0, i1;
      logic       g0, g1;
      logic [4:0] o;
      logic       v, s, b;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // r0 r1 i0 i1 | g0 g1 out v src busy  (DELAY=1 instance)
      tbl[0]  = '{1'b0, 1'b1, 5'h00, 5'h0A, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 5'h0A, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 5'h03, 5'h1C, 1'b1, 1'b0, 5'h0A, 1'b0, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 5'h1F, 5'h1C, 1'b0, 1'b0, 5'h03, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 5'h1F, 5'h1C, 1'b0, 1'b1, 5'h03, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 5'h1F, 5'h00, 1'b0, 1'b0, 5'h1C, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 5'h11, 5'h05, 1'b1, 1'b0, 5'h1C, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 5'h00, 5'h05, 1'b0, 1'b0, 5'h11, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 5'h07, 5'h19, 1'b0, 1'b1, 5'h11, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 5'h19, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 5'h19, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 5'h02, 5'h00, 1'b1, 1'b0, 5'h19, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 5'h02, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0};

      // reset state
      tick(); tick();
      chk("rst_gnt0", a_g0, 0); chk("rst_gnt1", a_g1, 0);
      chk("rst_out", a_o, 0);   chk("rst_valid", a_v, 0);
      chk("rst_src", a_s, 0);   chk("rst_busy", a_b, 0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("idle_busy", a_b, 0);

      // DELAY=1 table
      for (int i = 0; i < 14; i++) begin
         c_r0 = tbl[i].r0; c_r1 = tbl[i].r1;
         c_i0 = tbl[i].i0; c_i1 = tbl[i].i1;
         tick();
         chk($sformatf("c%0d_gnt0", i), c_g0, tbl[i].g0);
         chk($sformatf("c%0d_gnt1", i), c_g1, tbl[i].g1);
         chk($sformatf("c%0d_out", i), c_o, tbl[i].o);
         chk($sformatf("c%0d_valid", i), c_v, tbl[i].v);
         chk($sformatf("c%0d_src", i), c_s, tbl[i].s);
         chk($sformatf("c%0d_busy", i), c_b, tbl[i].b);
      end

      // SIZE=10 DELAY=20: continuous contention alternates, 21 cycles apart
      b_r0 = 1; b_r1 = 1; b_i0 = 10'h001; b_i1 = 10'h3FF;
      for (int c = 0; c <= 62; c++) begin
         tick();
         chk($sformatf("b%0d_gnt0", c), b_g0, (c == 0 || c == 42));
         chk($sformatf("b%0d_gnt1", c), b_g1, (c == 21));
         chk($sformatf("b%0d_valid", c), b_v, (c == 20 || c == 41 || c == 62));
         chk($sformatf("b%0d_busy", c), b_b, 1);
         if (c == 20 || c == 62) chk($sformatf("b%0d_out", c), b_o, 10'h001);
         if (c == 41)            chk($sformatf("b%0d_out", c), b_o, 10'h3FF);
         if (c == 62) begin b_r0 = 0; b_r1 = 0; end
      end
      tick();
      chk("b_end_busy", b_b, 0);
      chk("b_end_gnt", {b_g0, b_g1}, 2'b00);

      // DELAY=10: single grant, late req1 must wait for HOLD to end
      a_r0 = 1; a_i0 = 5'h15;
      tick();
      chk("a_grant_gnt0", a_g0, 1); chk("a_grant_busy", a_b, 1);
      a_r0 = 0; a_i0 = 5'h00;
      for (int k = 1; k <= 10; k++) begin
         if (k == 3) begin a_r1 = 1; a_i1 = 5'h0E; end
         tick();
         chk($sformatf("a%0d_gnt1", k), a_g1, 0);
         chk($sformatf("a%0d_busy", k), a_b, 1);
         chk($sformatf("a%0d_valid", k), a_v, (k == 10));
         if (k == 10) begin
            chk("a10_out", a_o, 5'h15); chk("a10_src", a_s, 0);
         end
      end
      tick();
      chk("a11_gnt1", a_g1, 1); chk("a11_valid", a_v, 0); chk("a11_out", a_o, 5'h15);
      a_r1 = 0; a_i1 = 5'h1F;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("a2_%0d_valid", k), a_v, (k == 10));
      end
      chk("a2_out", a_o, 5'h0E); chk("a2_src", a_s, 1);
      tick();
      chk("a2_idle_busy", a_b, 0); chk("a2_hold_out", a_o, 5'h0E); chk("a2_hold_src", a_s, 1);

      // asynchronous reset in the middle of HOLD
      a_r0 = 1; a_i0 = 5'h1B;
      tick();
      chk("ar_gnt0", a_g0, 1);
      a_r0 = 0;
      for (int k = 1; k <= 4; k++) tick();
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", a_b, 0); chk("ar_out", a_o, 0);
      chk("ar_valid", a_v, 0); chk("ar_src", a_s, 0);
      a_r0 = 1; a_r1 = 1; a_i0 = 5'h04; a_i1 = 5'h08;
      tick();
      chk("ar_held_gnt", {a_g0, a_g1}, 2'b00);
      chk("ar_held_valid", a_v, 0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("ar_first_gnt0", a_g0, 1); chk("ar_first_gnt1", a_g1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vdff_share_arbiter.md
VDFF_SHARE_ARBITER -- requirements
Module: vdff_share_arbiter

Interface
REQ-001 The block SHALL provide parameter SIZE, default 5, giving the data width in bits (1..64).
REQ-002 The block SHALL provide parameter DELAY, default 10, giving the capture-to-output delay in clock cycles (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req0, input, 1 bit: access request from requester 0.
REQ-006 The block SHALL have port req1, input, 1 bit: access request from requester 1.
REQ-007 The block SHALL have port in0, input, SIZE bits: data from requester 0.
REQ-008 The block SHALL have port in1, input, SIZE bits: data from requester 1.
REQ-009 The block SHALL have port gnt0, output, 1 bit: one-cycle grant pulse to requester 0.
REQ-010 The block SHALL have port gnt1, output, 1 bit: one-cycle grant pulse to requester 1.
REQ-011 The block SHALL have port out, output, SIZE bits: the shared delayed register value.
REQ-012 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking an update of out.
REQ-013 The block SHALL have port out_src, output, 1 bit: index of the requester whose data is on out.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a transaction is in flight.

Function
REQ-015 The block SHALL implement a two-state FSM (IDLE, HOLD), with all outputs registered.
REQ-016 In IDLE, at a rising edge with req0 or req1 high, the block SHALL grant exactly one requester, chosen by the arbitration rules below.
REQ-017 On that grant edge, the block SHALL:
  - set the matching gnt high for exactly one cycle;
  - load in0 or in1 into a SIZE-bit shadow register;
  - latch the winner index;
  - load the 8-bit down-counter with DELAY-1;
  - enter HOLD.
REQ-018 If only one request is high in IDLE, the block SHALL grant that requester.
REQ-019 If both requests are high in IDLE, the block SHALL grant the requester not granted last (round-robin).
REQ-020 In HOLD, the counter SHALL decrement by 1 per cycle while nonzero.
REQ-021 At the edge where the counter is 0 in HOLD, the block SHALL:
  - copy the shadow register to out;
  - drive out_src with the winner index;
  - pulse out_valid for one cycle;
  - record the winner as last-granted;
  - return to IDLE.
REQ-022 out SHALL update exactly DELAY rising edges after the grant edge; DELAY=1 gives update on the next edge.
REQ-023 busy SHALL be high from the grant edge until the out_valid edge, inclusive of the cycle in which out_valid is high.
REQ-024 No grant SHALL be issued at the out_valid edge; the earliest next grant is the following edge, giving a minimum period of DELAY+1 cycles per transaction.
REQ-025 Requests SHALL be ignored while in HOLD.
REQ-026 A requester SHALL hold req until it sees its gnt.
REQ-027 A request withdrawn before grant SHALL have no effect.
REQ-028 Input data changes after the grant edge SHALL NOT affect out (shadow isolation).
REQ-029 out and out_src SHALL retain their values between transactions.
REQ-030 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-031 No data value SHALL ever be truncated or extended; all paths are exactly SIZE bits.

Reset
REQ-032 While rst is high, the block SHALL hold the following values:
  - state IDLE;
  - gnt0, gnt1, out_valid and busy at 0;
  - out and the shadow register at 0;
  - out_src at 0 and the counter at 0;
  - last-granted at 1, so req0 wins the first contention.
REQ-033 Reset asserted during HOLD SHALL discard the in-flight transaction, with no out_valid pulse and out set to 0.
REQ-034 After rst is released, the first grant SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-035 With SIZE=5, DELAY=10: req0=1, in0=5'h15 for one grant, then in0=0 -> gnt0 pulse at edge N; out=5'h15, out_valid=1, out_src=0 at edge N+10; busy high for edges N..N+10.
REQ-036 With SIZE=10, DELAY=20: req0=req1=1 held continuously with in0=10'h001, in1=10'h3FF -> grants alternate gnt0, gnt1, gnt0, spaced 21 cycles apart; out sequence 001, 3FF, 001.
REQ-037 With DELAY=1: req1 pulse, in1=5'h0A -> gnt1 at edge N; out=5'h0A and out_valid at edge N+1; next possible grant at edge N+2.
REQ-038 With DELAY=10: req1 asserted 3 cycles after the req0 grant -> no gnt1 until HOLD ends; gnt1 at out_valid edge +1.
REQ-039 With DELAY=10: rst asserted 4 cycles after a grant -> out_valid never pulses; out=0, busy=0 immediately (asynchronous); after release, req0 and req1 both high -> gnt0 first.
